// File: rtl/swap_pkg.sv
// Shared types and sizing constants for the swap controller.
package swap_pkg;

  // Engine sequence: two reads, two writes, back to idle.
  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR_A,
    WR_B
  } state_t;

  localparam int unsigned default_address_width = 7;
  localparam int unsigned default_data_width    = 8;
  localparam int unsigned count_width           = 16;

  // True while the engine owns the register file read port.
  function automatic logic engine_reads(input state_t state);
    return (state == RD_A) || (state == RD_B);
  endfunction

  // True while the engine owns the register file write port.
  function automatic logic engine_writes(input state_t state);
    return (state == WR_A) || (state == WR_B);
  endfunction

endpackage

// File: rtl/swap_ctrl_if.sv
// Host-side bus of the swap controller: swap command handshake plus the
// shared host read and write ports. The host is the master.
interface swap_ctrl_if #(
  parameter int unsigned address_width = 7,
  parameter int unsigned data_width    = 8
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [address_width-1:0] cmd_addr_a;
  logic [address_width-1:0] cmd_addr_b;

  logic                     host_we;
  logic [address_width-1:0] host_addr_w;
  logic [data_width-1:0]    host_data_w;
  logic                     host_wready;

  logic [address_width-1:0] host_addr_r;
  logic [data_width-1:0]    host_data_r;
  logic                     host_rvalid;

  modport master (
    output cmd_valid, cmd_addr_a, cmd_addr_b,
    output host_we, host_addr_w, host_data_w, host_addr_r,
    input  cmd_ready, host_wready, host_data_r, host_rvalid
  );

  modport slave (
    input  cmd_valid, cmd_addr_a, cmd_addr_b,
    input  host_we, host_addr_w, host_data_w, host_addr_r,
    output cmd_ready, host_wready, host_data_r, host_rvalid
  );

endinterface

// File: rtl/swap_port_mux.sv
// Combinational arbitration of the register file ports between the swap
// engine and the host, including the host-write hazard check.
module swap_port_mux
  import swap_pkg::*;
#(
  parameter int unsigned address_width = default_address_width,
  parameter int unsigned data_width    = default_data_width
) (
  input  state_t                   state,
  input  logic [address_width-1:0] addr_a,
  input  logic [address_width-1:0] addr_b,
  input  logic [data_width-1:0]    tmp_a,
  input  logic [data_width-1:0]    tmp_b,
  input  logic                     host_we,
  input  logic [address_width-1:0] host_addr_w,
  input  logic [data_width-1:0]    host_data_w,
  input  logic [address_width-1:0] host_addr_r,
  output logic                     host_wready,
  output logic                     host_rvalid,
  output logic                     rf_we,
  output logic [address_width-1:0] rf_address_w,
  output logic [address_width-1:0] rf_address_r,
  output logic [data_width-1:0]    rf_data_w
);

  logic write_hazard;

  // A host write to either swap location must wait until the swap is done,
  // otherwise the engine would overwrite it with a stale value.
  assign write_hazard = (host_addr_w == addr_a) || (host_addr_w == addr_b);

  // Hand each port to the engine in its own phases, to the host otherwise.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    host_wready  = 1'b1;
    host_rvalid  = 1'b1;
    rf_address_r = host_addr_r;
    rf_address_w = host_addr_w;
    rf_data_w    = host_data_w;
    unique case (state)
      RD_A: begin
        rf_address_r = addr_a;
        host_rvalid  = 1'b0;
        host_wready  = !write_hazard;
      end
      RD_B: begin
        rf_address_r = addr_b;
        host_rvalid  = 1'b0;
        host_wready  = !write_hazard;
      end
      WR_A: begin
        host_wready  = 1'b0;
        rf_address_w = addr_a;
        rf_data_w    = tmp_b;
      end
      WR_B: begin
        host_wready  = 1'b0;
        rf_address_w = addr_b;
        rf_data_w    = tmp_a;
      end
      default: ;
    endcase
    rf_we = engine_writes(state) || (host_we && host_wready);
  end

endmodule

// File: rtl/swap_ctrl.sv
// Swap sequencer: accepts an address pair, reads both locations, writes
// them back exchanged, then pulses done and bumps the swap count.
module swap_ctrl
  import swap_pkg::*;
#(
  parameter int unsigned address_width = default_address_width,
  parameter int unsigned data_width    = default_data_width
) (
  input  logic                     clk,
  input  logic                     rst,
  swap_ctrl_if.slave               bus,
  output logic                     rf_we,
  output logic [address_width-1:0] rf_address_w,
  output logic [address_width-1:0] rf_address_r,
  output logic [data_width-1:0]    rf_data_w,
  input  logic [data_width-1:0]    rf_data_r,
  output logic                     busy,
  output logic                     done,
  output logic [count_width-1:0]   swap_count
);

  state_t                   state;
  logic [address_width-1:0] addr_a;
  logic [address_width-1:0] addr_b;
  logic [data_width-1:0]    tmp_a;
  logic [data_width-1:0]    tmp_b;

  assign bus.cmd_ready   = (state == IDLE);
  assign busy            = (state != IDLE);
  assign bus.host_data_r = rf_data_r;

  // Sequence the swap; reset drops straight back to IDLE so no further
  // engine write is issued and done never pulses for an aborted swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_a     <= '0;
      addr_b     <= '0;
      tmp_a      <= '0;
      tmp_b      <= '0;
      done       <= 1'b0;
      swap_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_a <= bus.cmd_addr_a;
            addr_b <= bus.cmd_addr_b;
            state  <= RD_A;
          end
        end
        RD_A: begin
          tmp_a <= rf_data_r;
          state <= RD_B;
        end
        RD_B: begin
          tmp_b <= rf_data_r;
          state <= WR_A;
        end
        WR_A: state <= WR_B;
        WR_B: begin
          done       <= 1'b1;
          swap_count <= swap_count + count_width'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  swap_port_mux #(
    .address_width(address_width),
    .data_width   (data_width)
  ) u_port_mux (
    .state       (state),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .tmp_a       (tmp_a),
    .tmp_b       (tmp_b),
    .host_we     (bus.host_we),
    .host_addr_w (bus.host_addr_w),
    .host_data_w (bus.host_data_w),
    .host_addr_r (bus.host_addr_r),
    .host_wready (bus.host_wready),
    .host_rvalid (bus.host_rvalid),
    .rf_we       (rf_we),
    .rf_address_w(rf_address_w),
    .rf_address_r(rf_address_r),
    .rf_data_w   (rf_data_w)
  );

endmodule

// File: tb/tb_swap_ctrl.sv
// Bench for swap_ctrl: attached register file, transaction-level reference
// model of memory and handshake outputs, directed scenarios and random traffic.
module tb_swap_ctrl;

  localparam int aw    = 7;
  localparam int dw    = 8;
  localparam int depth = 1 << aw;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  swap_ctrl_if #(.address_width(aw), .data_width(dw)) bus ();

  logic          rf_we;
  logic [aw-1:0] rf_address_w;
  logic [aw-1:0] rf_address_r;
  logic [dw-1:0] rf_data_w;
  logic [dw-1:0] rf_data_r;
  logic          busy;
  logic          done;
  logic [15:0]   swap_count;

  swap_ctrl #(.address_width(aw), .data_width(dw)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rf_we       (rf_we),
    .rf_address_w(rf_address_w),
    .rf_address_r(rf_address_r),
    .rf_data_w   (rf_data_w),
    .rf_data_r   (rf_data_r),
    .busy        (busy),
    .done        (done),
    .swap_count  (swap_count)
  );

  // Attached register file: asynchronous read, synchronous write, preload
  // puts value == address in locations 20..29 and zero elsewhere.
  logic          preload = 1'b1;
  logic [dw-1:0] mem [depth];
  assign rf_data_r = mem[rf_address_r];

  function automatic logic [dw-1:0] preload_value(input int i);
    return (i >= 20 && i <= 29) ? dw'(i) : '0;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < depth; i++) mem[i] <= preload_value(i);
    end else if (rf_we) begin
      mem[rf_address_w] <= rf_data_w;
    end
  end

  // Reference model: k counts cycles since the command was accepted
  // (0 = idle). The swap values are sampled at accept time, since writes to
  // the swap locations cannot land before the engine reads them.
  int            n_checks = 0;
  int            n_fail   = 0;
  int            k;
  logic [aw-1:0] m_a, m_b;
  logic [dw-1:0] m_va, m_vb;
  logic          exp_done;
  logic [15:0]   exp_count;
  logic [dw-1:0] ref_mem [depth];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    k         = 0;
    exp_done  = 1'b0;
    exp_count = '0;
  endtask

  function automatic logic exp_wready();
    if (k == 0) return 1'b1;
    if (k == 1 || k == 2) return !(bus.host_addr_w == m_a || bus.host_addr_w == m_b);
    return 1'b0;
  endfunction

  task automatic set_idle();
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr_a  = '0;
    bus.cmd_addr_b  = '0;
    bus.host_we     = 1'b0;
    bus.host_addr_w = '0;
    bus.host_data_w = '0;
    bus.host_addr_r = aw'($urandom_range(20, 29));
  endtask

  // One clock cycle: entered 1 ns after a rising edge with inputs driven,
  // checks outputs, advances the model over the edge, returns 1 ns after it.
  task automatic cycle();
    logic wr;
    #1;
    wr = exp_wready();
    check("cmd_ready", bus.cmd_ready, k == 0);
    check("busy", busy, k != 0);
    check("done", done, exp_done);
    check("swap_count", swap_count, exp_count);
    check("host_wready", bus.host_wready, wr);
    check("rf_we", rf_we, (k == 3 || k == 4) || (bus.host_we && wr));
    check("host_rvalid", bus.host_rvalid, !(k == 1 || k == 2));
    if (!(k == 1 || k == 2))
      check("host_data_r", bus.host_data_r, ref_mem[bus.host_addr_r]);
    @(posedge clk);
    if (bus.host_we && wr) ref_mem[bus.host_addr_w] = bus.host_data_w;
    if (k == 3) ref_mem[m_a] = m_vb;
    if (k == 4) ref_mem[m_b] = m_va;
    exp_done = (k == 4);
    if (k == 4) exp_count++;
    if (k == 0) begin
      if (bus.cmd_valid) begin
        m_a  = bus.cmd_addr_a;
        m_b  = bus.cmd_addr_b;
        m_va = ref_mem[m_a];
        m_vb = ref_mem[m_b];
        k    = 1;
      end
    end else begin
      k = (k == 4) ? 0 : k + 1;
    end
    #1;
  endtask

  // Reload both memories and reset the DUT across one rising edge.
  task automatic restart();
    set_idle();
    preload = 1'b1;
    rst     = 1'b1;
    model_reset();
    for (int i = 0; i < depth; i++) ref_mem[i] = preload_value(i);
    @(posedge clk);
    #1;
    preload = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic issue(input int a, input int b);
    bus.cmd_valid  = 1'b1;
    bus.cmd_addr_a = aw'(a);
    bus.cmd_addr_b = aw'(b);
    cycle();
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic compare_mem();
    for (int i = 0; i < depth; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
  endtask

  initial begin
    set_idle();
    model_reset();
    for (int i = 0; i < depth; i++) ref_mem[i] = preload_value(i);

    // Reset pulse of 2 ns.
    #1 rst = 1'b1;
    #1;
    check("reset rf_we", rf_we, 1'b0);
    check("reset done", done, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset swap_count", swap_count, 16'd0);
    check("reset cmd_ready", bus.cmd_ready, 1'b1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 preload = 1'b0;

    // Single swap of 22 and 28.
    issue(22, 28);
    repeat (6) cycle();
    check("single mem22", mem[22], 8'd28);
    check("single mem28", mem[28], 8'd22);
    check("single count", swap_count, 16'd1);

    // Back-to-back: cmd_valid held for two commands.
    restart();
    bus.cmd_valid  = 1'b1;
    bus.cmd_addr_a = 7'd22;
    bus.cmd_addr_b = 7'd28;
    repeat (6) cycle();
    bus.cmd_valid  = 1'b0;
    repeat (6) cycle();
    check("b2b mem22", mem[22], 8'd22);
    check("b2b mem28", mem[28], 8'd28);
    check("b2b count", swap_count, 16'd2);

    // Hazard: 0x55 to 25 in RD_A passes, 0xAA to 28 from RD_B stalls.
    restart();
    issue(22, 28);
    bus.host_we     = 1'b1;
    bus.host_addr_w = 7'd25;
    bus.host_data_w = 8'h55;
    #1 check("hazard wready 25", bus.host_wready, 1'b1);
    cycle();
    bus.host_addr_w = 7'd28;
    bus.host_data_w = 8'hAA;
    repeat (4) cycle();
    bus.host_we = 1'b0;
    repeat (2) cycle();
    check("hazard mem28", mem[28], 8'hAA);
    check("hazard mem22", mem[22], 8'd28);
    check("hazard mem25", mem[25], 8'h55);

    // Equal addresses.
    restart();
    issue(24, 24);
    repeat (6) cycle();
    check("equal mem24", mem[24], 8'd24);
    check("equal count", swap_count, 16'd1);

    // Reset asserted during WR_B, before its edge.
    restart();
    issue(22, 28);
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    check("abort rf_we", rf_we, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort cmd_ready", bus.cmd_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) cycle();
    check("abort mem22", mem[22], 8'd28);
    check("abort mem28", mem[28], 8'd28);
    check("abort count", swap_count, 16'd0);

    // Random commands and host traffic.
    restart();
    for (int n = 0; n < 600; n++) begin
      bus.cmd_valid   = ($urandom_range(0, 3) == 0);
      bus.cmd_addr_a  = aw'($urandom_range(20, 29));
      bus.cmd_addr_b  = aw'($urandom_range(20, 29));
      bus.host_we     = $urandom_range(0, 1) == 1;
      bus.host_addr_w = ($urandom_range(0, 4) == 0) ? aw'($urandom) : aw'($urandom_range(20, 29));
      bus.host_data_w = dw'($urandom);
      bus.host_addr_r = aw'($urandom_range(20, 29));
      cycle();
    end
    set_idle();
    repeat (6) cycle();
    compare_mem();
    check("random count", swap_count, exp_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
